// File: rtl/sign_extend.sv
// Registered immediate extender: sign/zero extend, upper load and branch offset, 1-cycle latency.
// Optional neg/zero status outputs are added when SIGN_EXTEND_STATUS_EN is defined.
module sign_extend #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  a,
    input  logic [1:0]       mode,
    output logic [OUT_W-1:0] y,
    output logic             out_valid
`ifdef SIGN_EXTEND_STATUS_EN
    ,
    output logic             neg,
    output logic             zero
`endif
);

    typedef enum logic [1:0] {
        MODE_SEXT   = 2'b00,
        MODE_ZEXT   = 2'b01,
        MODE_UPPER  = 2'b10,
        MODE_BRANCH = 2'b11
    } mode_e;

    localparam int EXT_W = OUT_W - IN_W;

    // The branch offset needs two spare bits above the immediate for the shift.
    if (OUT_W < IN_W + 2) begin : g_bad_width
        $error("sign_extend: OUT_W must be at least IN_W+2");
    end

    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] result;
    logic [OUT_W-1:0] y_d, y_q;
    logic             out_valid_d, out_valid_q;

    assign sext = {{EXT_W{a[IN_W-1]}}, a};

    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
        result = sext;
        unique case (mode_e'(mode))
            MODE_SEXT:   result = sext;
            MODE_ZEXT:   result = {{EXT_W{1'b0}}, a};
            MODE_UPPER:  result = {a, {EXT_W{1'b0}}};
            MODE_BRANCH: result = {sext[OUT_W-3:0], 2'b00};
            default:     result = sext;
        endcase
    end

    // Idle cycles hold the last result so a and mode cannot disturb y.
    always_comb begin
        y_d         = y_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            y_d         = result;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (!rst_n) begin
            y_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign y         = y_q;
    assign out_valid = out_valid_q;

`ifdef SIGN_EXTEND_STATUS_EN
    logic neg_d, neg_q;
    logic zero_d, zero_q;

    always_comb begin
        neg_d  = neg_q;
        zero_d = zero_q;
        if (in_valid) begin
            neg_d  = result[OUT_W-1];
            zero_d = (result == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            neg_q  <= neg_d;
            zero_q <= zero_d;
        end
    end

    assign neg  = neg_q;
    assign zero = zero_q;
`endif

endmodule

// File: tb/tb_sign_extend.sv
// Self-checking bench for sign_extend (default IN_W=16, OUT_W=32): directed vectors,
// reset behaviour and randomized traffic against an arithmetic reference model.
module tb_sign_extend;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] a;
    logic [1:0]  mode;
    logic [31:0] y;
    logic        out_valid;
`ifdef SIGN_EXTEND_STATUS_EN
    logic        neg;
    logic        zero;
`endif

    int checks   = 0;
    int failures = 0;
    logic [31:0] last_y;

    sign_extend #(.IN_W(16), .OUT_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .mode      (mode),
        .y         (y),
        .out_valid (out_valid)
`ifdef SIGN_EXTEND_STATUS_EN
        ,
        .neg       (neg),
        .zero      (zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model in plain integer arithmetic.
    function automatic logic [31:0] model(input logic [1:0] m, input logic [15:0] v);
        int s;
        s = int'($signed(v));
        case (m)
            2'd0:    return 32'(s);
            2'd1:    return 32'(v);
            2'd2:    return 32'(v) * 32'h0001_0000;
            default: return 32'(s * 4);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of input, then check the registered result just after the edge.
    task automatic step(input string tag, input logic v, input logic [1:0] m,
                        input logic [15:0] din, input logic [31:0] exp_y);
        @(negedge clk);
        in_valid = v;
        mode     = m;
        a        = din;
        @(posedge clk);
        #1;
        check({tag, ".out_valid"}, 32'(out_valid), 32'(v));
        check({tag, ".y"}, y, exp_y);
        last_y = exp_y;
    endtask

    initial begin
        logic        rv;
        logic [1:0]  rm;
        logic [15:0] ra;

        rst_n    = 1'b0;
        in_valid = 1'b1;
        mode     = 2'b00;
        a        = 16'hFFFF;
        last_y   = '0;
        #1;
        check("reset_async.y", y, 32'h0);
        check("reset_async.out_valid", 32'(out_valid), 32'h0);
        @(posedge clk);
        #1;
        check("reset_held.y", y, 32'h0);
        check("reset_held.out_valid", 32'(out_valid), 32'h0);

        // Release reset with in_valid low: first edge must show only reset values.
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset.y", y, 32'h0);
        check("post_reset.out_valid", 32'(out_valid), 32'h0);

        // Sign extend, back-to-back.
        step("sext_0000", 1'b1, 2'b00, 16'h0000, 32'h0000_0000);
`ifdef SIGN_EXTEND_STATUS_EN
        check("status_zero.neg", 32'(neg), 32'h0);
        check("status_zero.zero", 32'(zero), 32'h1);
`endif
        step("sext_0001", 1'b1, 2'b00, 16'h0001, 32'h0000_0001);
        step("sext_8000", 1'b1, 2'b00, 16'h8000, 32'hFFFF_8000);
`ifdef SIGN_EXTEND_STATUS_EN
        check("status_neg.neg", 32'(neg), 32'h1);
        check("status_neg.zero", 32'(zero), 32'h0);
`endif
        step("sext_ffff", 1'b1, 2'b00, 16'hFFFF, 32'hFFFF_FFFF);
        step("sext_7fff", 1'b1, 2'b00, 16'h7FFF, 32'h0000_7FFF);

        step("zext_8000", 1'b1, 2'b01, 16'h8000, 32'h0000_8000);
        step("upper_1234", 1'b1, 2'b10, 16'h1234, 32'h1234_0000);
        step("branch_ffff", 1'b1, 2'b11, 16'hFFFF, 32'hFFFF_FFFC);
        step("branch_7fff", 1'b1, 2'b11, 16'h7FFF, 32'h0001_FFFC);

        // Boundary: zero input in every mode, MSB set in every mode.
        step("zero_m0", 1'b1, 2'b00, 16'h0000, 32'h0);
        step("zero_m1", 1'b1, 2'b01, 16'h0000, 32'h0);
        step("zero_m2", 1'b1, 2'b10, 16'h0000, 32'h0);
        step("zero_m3", 1'b1, 2'b11, 16'h0000, 32'h0);
        step("msb_m1", 1'b1, 2'b01, 16'h8001, 32'h0000_8001);
        step("msb_m2", 1'b1, 2'b10, 16'h8001, 32'h8001_0000);
        step("msb_m3", 1'b1, 2'b11, 16'h8001, 32'hFFFE_0004);

        // Idle cycles with changing a/mode: y holds, out_valid low.
        step("idle_a", 1'b0, 2'b00, 16'hFFFF, 32'hFFFE_0004);
        step("idle_b", 1'b0, 2'b10, 16'h5A5A, 32'hFFFE_0004);

        // Mid-stream reset between edges.
        step("pre_rst", 1'b1, 2'b01, 16'hBEEF, 32'h0000_BEEF);
        @(negedge clk);
        in_valid = 1'b1;
        a        = 16'h1111;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst.y", y, 32'h0);
        check("mid_rst.out_valid", 32'(out_valid), 32'h0);
        @(posedge clk);
        #1;
        check("mid_rst_edge.y", y, 32'h0);
        check("mid_rst_edge.out_valid", 32'(out_valid), 32'h0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        check("rst_release.out_valid", 32'(out_valid), 32'h0);
        check("rst_release.y", y, 32'h0);
        last_y = '0;

        // Randomized traffic against the reference model.
        for (int i = 0; i < 300; i++) begin
            rv = ($urandom_range(3) != 0);
            rm = 2'($urandom_range(3));
            ra = 16'($urandom);
            step("rand", rv, rm, ra, rv ? model(rm, ra) : last_y);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
